gate_g_bank: RTL and testbench

Parametrised multi-channel successor to the single gated D register.
- CHANNELS independent WIDTH-bit registers, each loaded by its own enable.
- Per-channel idle detection gates a channel after IDLE_CYCLES consecutive unused cycles.
- A gated channel needs a WAKE_CYCLES wake-up before it accepts data again.
- Sits between the datapath producers and the power-management logic. The gated outputs act as clock-gate requests.

---
 rtl/gate_g_bank.sv | 119 +++++++++++
 tb/tb_gate_g_bank.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/gate_g_bank.sv
// Multi-channel gated register bank. Each channel is a WIDTH-bit register with
// its own idle detector that drops it into GATED and a WAKE delay on re-entry.

module gate_g_chan #(
  parameter int WIDTH       = 8,
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_en,
  input  logic             i_bypass,
  output logic [WIDTH-1:0] o_q,
  output logic             o_ready,
  output logic             o_gated
);
  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {ACTIVE, GATED, WAKE} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idle;
  logic [WW-1:0]    r_wake;
  logic [WIDTH-1:0] r_q;
  logic             w_ready;
  logic             w_load;

  assign w_ready = (r_state == ACTIVE);
  assign w_load  = i_en & w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACTIVE;
      r_idle  <= '0;
      r_wake  <= '0;
      r_q     <= '0;
    end else begin
      // Load is gated by the pre-edge state, so bypass never lets a
      // GATED/WAKE channel capture on the edge that wakes it.
      if (w_load) r_q <= i_d;
      if (i_bypass) begin
        r_state <= ACTIVE;
        r_idle  <= '0;
        r_wake  <= '0;
      end else begin
        unique case (r_state)
          ACTIVE: begin
            if (i_en) begin
              r_idle <= '0;
            end else if (r_idle == IDLE_LAST) begin
              r_state <= GATED;
              r_idle  <= '0;
            end else begin
              r_idle <= r_idle + IW'(1);
            end
          end
          GATED: begin
            if (i_en) begin
              r_state <= WAKE;
              r_wake  <= '0;
            end
          end
          WAKE: begin
            if (r_wake == WAKE_LAST) r_state <= ACTIVE;
            else                     r_wake  <= r_wake + WW'(1);
          end
          default: r_state <= ACTIVE;
        endcase
      end
    end
  end

  assign o_q     = r_q;
  assign o_ready = w_ready;
  assign o_gated = (r_state == GATED);
endmodule

module gate_g_bank #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH*CHANNELS-1:0] d,
  input  logic [CHANNELS-1:0]       enable,
  input  logic                      gate_bypass,
  output logic [WIDTH*CHANNELS-1:0] q,
  output logic [CHANNELS-1:0]       ready,
  output logic [CHANNELS-1:0]       gated
);
  logic [CHANNELS-1:0][WIDTH-1:0] w_d;
  logic [CHANNELS-1:0][WIDTH-1:0] w_q;

  assign w_d = d;
  assign q   = w_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    gate_g_chan #(
      .WIDTH      (WIDTH),
      .IDLE_CYCLES(IDLE_CYCLES),
      .WAKE_CYCLES(WAKE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_d     (w_d[i]),
      .i_en    (enable[i]),
      .i_bypass(gate_bypass),
      .o_q     (w_q[i]),
      .o_ready (ready[i]),
      .o_gated (gated[i])
    );
  end
endmodule

// File: tb/tb_gate_g_bank.sv
// Directed bench for gate_g_bank: expected outputs are queued with each step
// and checked one cycle later, just after the clock edge.

module tb_gate_g_bank;
  localparam int W = 8;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W*C-1:0] d = '0;
  logic [C-1:0]   enable = '0;
  logic           gate_bypass = 1'b0;
  logic [W*C-1:0] q;
  logic [C-1:0]   ready;
  logic [C-1:0]   gated;

  gate_g_bank #(.WIDTH(W), .CHANNELS(C), .IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d          (d),
    .enable     (enable),
    .gate_bypass(gate_bypass),
    .q          (q),
    .ready      (ready),
    .gated      (gated)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W*C-1:0] q;
    logic [C-1:0]   rdy;
    logic [C-1:0]   gtd;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    errors = 0;
  int    checks = 0;

  function automatic logic [W*C-1:0] qv(input logic [7:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic cmp(input string tag, input exp_t e);
    checks++;
    assert (q === e.q) else begin
      errors++; $error("FAIL %s q: got %h want %h", tag, q, e.q);
    end
    checks++;
    assert (ready === e.rdy) else begin
      errors++; $error("FAIL %s ready: got %b want %b", tag, ready, e.rdy);
    end
    checks++;
    assert (gated === e.gtd) else begin
      errors++; $error("FAIL %s gated: got %b want %b", tag, gated, e.gtd);
    end
  endtask

  task automatic push(input string tag, input logic [W*C-1:0] eq,
                      input logic [C-1:0] er, input logic [C-1:0] eg);
    exp_t e;
    e.q = eq; e.rdy = er; e.gtd = eg;
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic drain();
    while (sb.size() > 0) cmp(tags.pop_front(), sb.pop_front());
  endtask

  // Expectation for the outputs after the next rising edge.
  task automatic step(input string tag, input logic [W*C-1:0] eq,
                      input logic [C-1:0] er, input logic [C-1:0] eg);
    push(tag, eq, er, eg);
    @(posedge clk);
    #1;
    drain();
  endtask

  // Expectation for the outputs right now, no edge involved.
  task automatic now(input string tag, input logic [W*C-1:0] eq,
                     input logic [C-1:0] er, input logic [C-1:0] eg);
    push(tag, eq, er, eg);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W*C-1:0] q1, q2, q3, q4;
    q1 = qv(8'h00, 8'h00, 8'h00, 8'hA5);
    q2 = qv(8'h00, 8'h00, 8'h3C, 8'hA5);
    q3 = qv(8'h00, 8'h00, 8'h3C, 8'h77);
    q4 = qv(8'h00, 8'h5A, 8'h3C, 8'h77);

    #12;
    now("reset", '0, 4'b1111, 4'b0000);
    rst_n = 1'b1;

    // Load channel 0; channels 1-3 take their first idle edge here.
    enable = 4'b0001; d = q1;
    step("s1_load", q1, 4'b1111, 4'b0000);
    enable = '0; d = '0;

    step("s2_idle1", q1, 4'b1111, 4'b0000);
    step("s2_idle2", q1, 4'b1111, 4'b0000);
    step("s2_idle3", q1, 4'b0001, 4'b1110);
    step("s2_idle4", q1, 4'b0000, 4'b1111);

    // Wake channel 1 with enable held; data must not be captured until ready.
    enable = 4'b0010; d = qv(8'h00, 8'h00, 8'h3C, 8'h00);
    step("s3_wake1", q1, 4'b0000, 4'b1101);
    step("s3_wake2", q1, 4'b0000, 4'b1101);
    step("s3_ready", q1, 4'b0010, 4'b1101);
    step("s3_load",  q2, 4'b0010, 4'b1101);
    enable = '0; d = '0;
    for (int i = 0; i < 3; i++) step("s3_idle", q2, 4'b0010, 4'b1101);
    step("s3_regate", q2, 4'b0000, 4'b1111);

    gate_bypass = 1'b1;
    for (int i = 0; i < 10; i++) step("s5_bypass", q2, 4'b1111, 4'b0000);
    gate_bypass = 1'b0;
    for (int i = 0; i < 3; i++) step("s5_post", q2, 4'b1111, 4'b0000);
    step("s5_gate", q2, 4'b0000, 4'b1111);

    // Bypass onto a gated channel: no load that edge, load on the next.
    gate_bypass = 1'b1; enable = 4'b0001; d = q3;
    step("byp_gated_noload", q2, 4'b1111, 4'b0000);
    step("byp_active_load",  q3, 4'b1111, 4'b0000);
    gate_bypass = 1'b0; enable = '0; d = '0;

    // Load on the terminal idle count keeps channel 2 awake.
    for (int i = 0; i < 3; i++) step("s4_idle", q3, 4'b1111, 4'b0000);
    enable = 4'b0100; d = qv(8'h00, 8'h5A, 8'h00, 8'h00);
    step("s4_load", q4, 4'b0100, 4'b1011);
    enable = '0; d = '0;
    for (int i = 0; i < 3; i++) step("s4_hold", q4, 4'b0100, 4'b1011);
    step("s4_gate", q4, 4'b0000, 4'b1111);

    enable = 4'b0001;
    step("s6_wake", q4, 4'b0000, 4'b1110);
    enable = '0;
    #3 rst_n = 1'b0;
    #1;
    now("s6_async_rst", '0, 4'b1111, 4'b0000);
    #1 rst_n = 1'b1;
    enable = 4'b0001; d = q1;
    step("s6_reload", q1, 4'b1111, 4'b0000);
    enable = '0; d = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
